riscv_if_prefetch: RTL

Instruction prefetch buffer between the instruction memory bus and the instruction fetch stage. It issues word fetches for the IF stage's next-PC, matches in-order responses to their PCs, and queues fetched parcels in a small FIFO. After an IF flush it drops responses that are still in flight and reports misaligned-PC and bus-error faults alongside each parcel.

---
 rtl/riscv_if_prefetch_if.sv | 31 +++
 rtl/riscv_if_prefetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/riscv_if_prefetch_if.sv
// riscv_if_prefetch_if
// Instruction memory bus between the prefetch buffer (master) and the
// instruction memory (slave). Requests and responses are decoupled, and
// responses come back strictly in request order.
//   mem_req    master->slave  fetch request
//   mem_adr    master->slave  word-aligned fetch address
//   mem_ack    slave->master  request accepted this cycle
//   mem_rvalid slave->master  response valid
//   mem_rdata  slave->master  response data
//   mem_err    slave->master  response is a bus error (qualified by mem_rvalid)
interface riscv_if_prefetch_if #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32
) ();
  logic                   mem_req;
  logic [XLEN-1:0]        mem_adr;
  logic                   mem_ack;
  logic                   mem_rvalid;
  logic [PARCEL_SIZE-1:0] mem_rdata;
  logic                   mem_err;

  modport master (
    output mem_req, mem_adr,
    input  mem_ack, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_adr,
    output mem_ack, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/riscv_if_prefetch.sv
// riscv_if_prefetch
// Prefetch buffer between the instruction memory bus and the IF stage.
// Issues word fetches for if_nxt_pc, pairs in-order responses with their PCs
// through a tag queue, and buffers the parcels in a DEPTH-entry FIFO. A flush
// empties the buffers and turns every in-flight request into one whose
// response is silently dropped.
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   if_nxt_pc               PC the IF stage wants fetched next
//   if_stall                IF cannot take a parcel this cycle
//   if_flush                discard everything buffered and in flight
//   if_stall_nxt_pc         request not accepted; IF must hold if_nxt_pc
//   if_parcel, if_parcel_pc head-of-FIFO data and its PC
//   if_parcel_valid         all ones when the head entry is valid
//   if_parcel_misaligned    head PC had [1:0] != 0
//   if_parcel_page_fault    head response carried mem_err
//   mem                     instruction memory bus (master side)
module riscv_if_prefetch #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4
) (
  input  logic                      rstn,
  input  logic                      clk,
  input  logic [XLEN-1:0]           if_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic                      if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_page_fault,
  riscv_if_prefetch_if.master       mem
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = PARCEL_SIZE / 16;
  localparam logic [CW+1:0] DEPTH_C = (CW + 2)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0] fifo_cnt_reg, live_reg, drop_reg;
  logic [AW-1:0] fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [AW-1:0] tag_wr_ptr_reg, tag_rd_ptr_reg;

  logic [XLEN-1:0]        tag_pc_mem    [DEPTH];
  logic                   tag_mis_mem   [DEPTH];
  logic [XLEN-1:0]        fifo_pc_mem   [DEPTH];
  logic [PARCEL_SIZE-1:0] fifo_data_mem [DEPTH];
  logic                   fifo_mis_mem  [DEPTH];
  logic                   fifo_err_mem  [DEPTH];

  logic          run, req, accept, empty, pop, resp_keep, resp_drop;
  logic [CW+1:0] credit_sum;
  logic [CW-1:0] flush_drop_dec;

  // One idle cycle after reset before the first request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  assign run = (state_reg == ST_RUN);

  // Credits use registered counts only, so a same-cycle pop frees nothing.
  assign credit_sum = {2'b00, fifo_cnt_reg} + {2'b00, live_reg} + {2'b00, drop_reg};
  assign req        = run & ~if_flush & (credit_sum < DEPTH_C);
  assign accept     = req & mem.mem_ack;
  assign empty      = (fifo_cnt_reg == '0);
  assign pop        = ~empty & ~if_stall & ~if_flush;

  // Responses owed to pre-flush requests are consumed first; a response with
  // nothing outstanding is a bus protocol error and is ignored.
  assign resp_drop  = mem.mem_rvalid & ~if_flush & (drop_reg != '0);
  assign resp_keep  = mem.mem_rvalid & ~if_flush & (drop_reg == '0) & (live_reg != '0);

  // A response in the flush cycle retires one of the requests being dropped.
  assign flush_drop_dec = CW'(mem.mem_rvalid & ((drop_reg != '0) | (live_reg != '0)));

  assign mem.mem_req  = req;
  assign mem.mem_adr  = {if_nxt_pc[XLEN-1:2], 2'b00};
  assign if_stall_nxt_pc = ~accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_cnt_reg    <= '0;
      live_reg        <= '0;
      drop_reg        <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
    end else if (if_flush) begin
      fifo_cnt_reg    <= '0;
      live_reg        <= '0;
      drop_reg        <= drop_reg + live_reg - flush_drop_dec;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
    end else begin
      fifo_cnt_reg <= fifo_cnt_reg + CW'(resp_keep) - CW'(pop);
      live_reg     <= live_reg + CW'(accept) - CW'(resp_keep);
      if (resp_drop) drop_reg        <= drop_reg - 1'b1;
      if (accept)    tag_wr_ptr_reg  <= tag_wr_ptr_reg + 1'b1;
      if (resp_keep) tag_rd_ptr_reg  <= tag_rd_ptr_reg + 1'b1;
      if (resp_keep) fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 1'b1;
      if (pop)       fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 1'b1;
    end
  end

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_pc_mem[i]    <= '0;
        tag_mis_mem[i]   <= 1'b0;
        fifo_pc_mem[i]   <= '0;
        fifo_data_mem[i] <= '0;
        fifo_mis_mem[i]  <= 1'b0;
        fifo_err_mem[i]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        tag_pc_mem[tag_wr_ptr_reg]  <= if_nxt_pc;
        tag_mis_mem[tag_wr_ptr_reg] <= (if_nxt_pc[1:0] != 2'b00);
      end
      if (resp_keep) begin
        fifo_pc_mem[fifo_wr_ptr_reg]   <= tag_pc_mem[tag_rd_ptr_reg];
        fifo_data_mem[fifo_wr_ptr_reg] <= mem.mem_rdata;
        fifo_mis_mem[fifo_wr_ptr_reg]  <= tag_mis_mem[tag_rd_ptr_reg];
        fifo_err_mem[fifo_wr_ptr_reg]  <= mem.mem_err;
      end
    end
  end

  assign if_parcel            = fifo_data_mem[fifo_rd_ptr_reg];
  assign if_parcel_pc         = fifo_pc_mem[fifo_rd_ptr_reg];
  assign if_parcel_misaligned = fifo_mis_mem[fifo_rd_ptr_reg];
  assign if_parcel_page_fault = fifo_err_mem[fifo_rd_ptr_reg];
  assign if_parcel_valid      = {VW{~empty & ~if_flush}};

endmodule
